// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer with synchronous reset, clear, push, pop, occupancy and head.
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0],
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  T              wdata_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage is not reset; entries are only visible through count_o.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the PC, issues in-order imem requests, buffers responses,
// and drops wrong-path responses after a redirect. FETCH_PERF_EN adds perf counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output logic [31:0] if_npc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d;
  logic [CW-1:0] q_count, a_count;
  fetch_entry_t  q_head, q_wdata;
  logic [31:0]   a_head;
  logic          accept, q_push, q_pop;

  // Credit rule: in-flight plus buffered never exceeds DEPTH, so a response always fits.
  assign imem_req_valid = !reset && (state_q == RUN) && !redirect_valid &&
                          (({1'b0, out_q} + {1'b0, q_count}) < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign if_valid = (q_count != '0);
  assign if_ir    = if_valid ? q_head.ir  : NOP_INSTR;
  assign if_npc   = if_valid ? q_head.npc : 32'h0;

  assign q_push  = imem_rsp_valid && !redirect_valid && (disc_q == '0);
  assign q_pop   = if_valid && !stall && !redirect_valid;
  assign q_wdata = '{ir: imem_rsp_data, npc: a_head + 32'd4};

  always_comb begin
    out_d   = out_q + CW'(accept) - CW'(imem_rsp_valid);
    pc_d    = accept ? pc_q + 32'd4 : pc_q;
    disc_d  = disc_q;
    state_d = state_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle's response is wrong-path.
      pc_d    = redirect_pc;
      disc_d  = out_d;
      state_d = (out_d != '0) ? DRAIN : RUN;
    end else begin
      if (imem_rsp_valid && (disc_q != '0)) disc_d = disc_q - 1'b1;
      if ((state_q == DRAIN) && (disc_d == '0)) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect_valid),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .wdata_i (q_wdata),
    .head_o  (q_head),
    .count_o (q_count)
  );

  // Request addresses, popped by every response (dropped ones included) to recover npc.
  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_inflight (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .push_i  (accept),
    .pop_i   (imem_rsp_valid),
    .wdata_i (imem_req_addr),
    .head_o  (a_head),
    .count_o (a_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rsp_valid && (out_q == '0)));
      assert (a_count == out_q);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (if_valid && stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid && (perf_flush_q != '1))    perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: hand-derived streaming table, directed corner
// sequences, and randomized traffic against a queue-level reference model.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_ir, if_npc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_ir          (if_ir),
    .if_npc         (if_npc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int last_due = 0;
  logic rsp_now;

  // imem environment: in-order responses with data == address
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  // reference model: in-flight fetches tagged stale on redirect, plus delivered queue
  typedef struct { logic [31:0] addr; bit stale; } fl_t;
  typedef struct { logic [31:0] ir; logic [31:0] npc; } ent_t;
  fl_t  infl[$];
  ent_t deliv[$];
  logic [31:0] mpc = RPC;

  typedef struct packed {
    logic        stall;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ir;
    logic [31:0] npc;
  } vec_t;
  vec_t tbl[22];

  function automatic vec_t mk(logic st, logic rv, logic [31:0] a, logic iv,
                              logic [31:0] ir, logic [31:0] npc);
    vec_t v;
    v.stall = st; v.rv = rv; v.addr = a; v.iv = iv; v.ir = ir; v.npc = npc;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic exp_rv();
    int s = 0;
    foreach (infl[i]) if (infl[i].stale) s++;
    return !reset && (s == 0) && !redirect_valid && ((infl.size() + deliv.size()) < DEPTH);
  endfunction

  task automatic settle();
    rsp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? pend[0].addr : 32'h0;
    #1;
  endtask

  task automatic advance();
    logic rv_m, acc_m, acc_d;
    logic [31:0] a_d;
    int due;
    fl_t f;
    rv_m = exp_rv();
    if (!reset) begin
      chk("req_valid", imem_req_valid, rv_m);
      chk("req_addr", imem_req_addr, mpc);
      chk("if_valid", if_valid, deliv.size() != 0);
      chk("if_ir", if_ir, (deliv.size() != 0) ? deliv[0].ir : NOP_INSTR);
      chk("if_npc", if_npc, (deliv.size() != 0) ? deliv[0].npc : 32'h0);
    end
    acc_d = imem_req_valid && imem_req_ready && !reset;
    acc_m = rv_m && imem_req_ready;
    a_d   = imem_req_addr;
    @(posedge clk);
    if (reset) begin
      pend.delete(); infl.delete(); deliv.delete();
      mpc = RPC; last_due = 0;
    end else begin
      if (rsp_now) void'(pend.pop_front());
      if (acc_d) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{a_d, due});
      end
      if (redirect_valid) begin
        foreach (infl[i]) infl[i].stale = 1'b1;
        deliv.delete();
        mpc = redirect_pc;
      end else if ((deliv.size() > 0) && !stall) begin
        void'(deliv.pop_front());
      end
      if (rsp_now && (infl.size() > 0)) begin
        f = infl.pop_front();
        if (!f.stale) deliv.push_back('{f.addr, f.addr + 32'd4});
      end
      if (acc_m) begin
        infl.push_back('{mpc, 1'b0});
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; stall = 1'b0;
    step();
    settle();
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_ir", if_ir, NOP_INSTR);
    chk("rst_if_npc", if_npc, 32'h0);
    chk("rst_req_addr", imem_req_addr, RPC);
    advance();
    reset = 1'b0;
  endtask

  task automatic wait_iv(string nm, logic [31:0] eir, logic [31:0] enpc);
    int n = 0;
    settle();
    while (!if_valid && n < 30) begin
      advance(); settle(); n++;
    end
    chk({nm, "_seen"}, if_valid, 1'b1);
    chk({nm, "_ir"}, if_ir, eir);
    chk({nm, "_npc"}, if_npc, enpc);
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, waited, exp_wait;
    reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    @(negedge clk);

    // streaming then 10 stalled cycles, 1-cycle imem, always ready
    k = 0;
    tbl[k++] = mk(0, 1, 32'h00, 0, NOP_INSTR, 32'h0);
    tbl[k++] = mk(0, 1, 32'h04, 0, NOP_INSTR, 32'h0);
    tbl[k++] = mk(0, 1, 32'h08, 1, 32'h00, 32'h04);
    tbl[k++] = mk(0, 1, 32'h0C, 1, 32'h04, 32'h08);
    tbl[k++] = mk(0, 1, 32'h10, 1, 32'h08, 32'h0C);
    tbl[k++] = mk(0, 1, 32'h14, 1, 32'h0C, 32'h10);
    tbl[k++] = mk(1, 1, 32'h18, 1, 32'h10, 32'h14);
    tbl[k++] = mk(1, 1, 32'h1C, 1, 32'h10, 32'h14);
    for (int i = 0; i < 8; i++) tbl[k++] = mk(1, 0, 32'h20, 1, 32'h10, 32'h14);
    tbl[k++] = mk(0, 0, 32'h20, 1, 32'h10, 32'h14);
    tbl[k++] = mk(0, 1, 32'h20, 1, 32'h14, 32'h18);
    tbl[k++] = mk(0, 1, 32'h24, 1, 32'h18, 32'h1C);
    tbl[k++] = mk(0, 1, 32'h28, 1, 32'h1C, 32'h20);
    tbl[k++] = mk(0, 1, 32'h2C, 1, 32'h20, 32'h24);
    tbl[k++] = mk(0, 1, 32'h30, 1, 32'h24, 32'h28);

    do_reset();
    lat = 1;
    for (int i = 0; i < k; i++) begin
      stall = tbl[i].stall;
      settle();
      chk($sformatf("tbl%0d_rv", i), imem_req_valid, tbl[i].rv);
      chk($sformatf("tbl%0d_addr", i), imem_req_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_iv", i), if_valid, tbl[i].iv);
      chk($sformatf("tbl%0d_ir", i), if_ir, tbl[i].ir);
      chk($sformatf("tbl%0d_npc", i), if_npc, tbl[i].npc);
      advance();
    end
    stall = 1'b0;

    // redirect with two requests in flight, imem latency 3
    do_reset();
    lat = 3;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    settle();
    chk("rd_withdrawn", imem_req_valid, 1'b0);
    exp_wait = last_due - cyc;
    advance();
    redirect_valid = 1'b0;
    waited = 0;
    settle();
    while (!imem_req_valid && waited < 30) begin
      advance(); settle(); waited++;
    end
    chk("rd_drain_cycles", waited, exp_wait);
    chk("rd_addr", imem_req_addr, 32'h100);
    advance();
    wait_iv("rd_first", 32'h100, 32'h104);

    // redirect + stall + response together with three buffered entries
    do_reset();
    lat = 1; stall = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    settle();
    chk("sim_pre_rsp_ok", if_valid, 1'b1);
    advance();
    redirect_valid = 1'b0; stall = 1'b0;
    settle();
    chk("sim_iv", if_valid, 1'b0);
    chk("sim_ir", if_ir, NOP_INSTR);
    chk("sim_rv", imem_req_valid, 1'b1);
    chk("sim_pc", imem_req_addr, 32'h200);
    advance();
    wait_iv("sim_first", 32'h200, 32'h204);

    // reset while draining two stale responses
    do_reset();
    lat = 3;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("rstd_iv", if_valid, 1'b0);
    chk("rstd_ir", if_ir, NOP_INSTR);
    chk("rstd_npc", if_npc, 32'h0);
    chk("rstd_addr", imem_req_addr, RPC);
    chk("rstd_rv", imem_req_valid, 1'b1);
    advance();
    wait_iv("rstd_first", RPC, RPC + 32'd4);

    // PC wrap
    do_reset();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; lat = 1;
    settle();
    chk("wrap_rv", imem_req_valid, 1'b1);
    chk("wrap_a0", imem_req_addr, 32'hFFFF_FFFC);
    advance();
    settle();
    chk("wrap_a1", imem_req_addr, 32'h0);
    advance();
    wait_iv("wrap_first", 32'hFFFF_FFFC, 32'h0);

`ifdef FETCH_PERF_EN
    do_reset();
    chk("perf_stall_rst", perf_stall_cycles, 32'd0);
    chk("perf_flush_rst", perf_flushes, 32'd0);
    lat = 1;
    step(); step();
    stall = 1'b1;
    repeat (5) step();
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h400; step();
    redirect_valid = 1'b0; step();
    redirect_valid = 1'b1; redirect_pc = 32'h500; step();
    redirect_valid = 1'b0;
    settle();
    chk("perf_stall", perf_stall_cycles, 32'd5);
    chk("perf_flush", perf_flushes, 32'd2);
    advance();
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                                   : ($urandom & 32'hFFFF_FFFC);
      lat            = $urandom_range(1, 4);
      reset          = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
